// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
//
// Decode stage for RV32I ALU control. An instruction accepted on the upstream
// valid/ready handshake is decoded into an ALU operation plus an operand-B
// select. The result is registered and offered to the execute stage on a
// second valid/ready handshake. Illegal instructions handed downstream are
// counted in a saturating counter.
//
// Build option:
//   ALU_DEC_SKID_EN  - when defined, a 2-entry skid buffer sits behind the
//                      decoder and o_ready comes straight from a flop.
//                      When undefined, there is a single output register and
//                      o_ready = !o_valid || i_ready.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_flush        drop every held entry; ignore i_valid this cycle
//   i_valid/o_ready/i_instr           upstream handshake + instruction word
//   o_valid/i_ready                   downstream handshake
//   o_alu_ctrl     ALU operation (alu_op_t)
//   o_src_b_imm    operand B from immediate (1) or rs2 (0)
//   o_illegal      decoded operation is OP_INVALID
//   o_illegal_cnt  saturating count of illegal results handed downstream
// ---------------------------------------------------------------------------

package alu_op_decoder_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_SLL     = 4'd2,
        OP_SLT     = 4'd3,
        OP_SLTU    = 4'd4,
        OP_XOR     = 4'd5,
        OP_SRL     = 4'd6,
        OP_SRA     = 4'd7,
        OP_OR      = 4'd8,
        OP_AND     = 4'd9,
        OP_INVALID = 4'hF
    } alu_op_t;

    // One decoded result as held in the output/skid registers.
    typedef struct packed {
        alu_op_t op;
        logic    imm;
        logic    ill;
    } dec_t;

endpackage

module alu_op_decoder
    import alu_op_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    output logic             o_valid,
    input  logic             i_ready,
    output alu_op_t          o_alu_ctrl,
    output logic             o_src_b_imm,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam dec_t DEC_RST = '{op: OP_INVALID, imm: 1'b0, ill: 1'b0};

    // Register-number and immediate fields play no part in ALU selection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    dec_t       dec;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // Shared funct3 map of OP / OP-IMM (funct7 qualification done by caller).
    function automatic alu_op_t f3_map(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        dec.op  = OP_INVALID;
        dec.imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO)
                    dec.op = f3_map(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    dec.op = OP_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    dec.op = OP_SRA;
            end
            OPC_OPIMM: begin
                // Only the shift-immediates constrain funct7 (imm[11:5]).
                dec.imm = 1'b1;
                case (funct3)
                    3'b001: if (funct7 == F7_ZERO) dec.op = OP_SLL;
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec.op = OP_SRL;
                        else if (funct7 == F7_ALT) dec.op = OP_SRA;
                    end
                    default: dec.op = f3_map(funct3);
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                // Address / link / upper-immediate formation all use ADD.
                dec.op  = OP_ADD;
                dec.imm = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec.op = OP_SUB;   // BEQ/BNE
                    3'b100, 3'b101: dec.op = OP_SLT;   // BLT/BGE
                    3'b110, 3'b111: dec.op = OP_SLTU;  // BLTU/BGEU
                    default:        dec.op = OP_INVALID;
                endcase
            end
            default: ;
        endcase
        dec.ill = (dec.op == OP_INVALID);
    end

    // -----------------------------------------------------------------------
    // Handshake, output register(s), illegal counter
    // -----------------------------------------------------------------------
    dec_t             out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up_xfer, dn_xfer;

    // Flush suppresses both transfers so neither is counted nor stored.
    assign up_xfer = i_valid && o_ready && !i_flush;
    assign dn_xfer = out_vld_q && i_ready && !i_flush;

`ifdef ALU_DEC_SKID_EN
    dec_t skid_q, skid_d;
    logic skid_vld_q, skid_vld_d;
    logic rdy_q, rdy_d;

    // rdy_q resets high so o_ready rises as soon as reset is released.
    assign o_ready = i_rst_n && rdy_q;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // Full: upstream is stalled (rdy_q low), only drain.
            if (dn_xfer) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (out_vld_q) begin
            if (up_xfer && dn_xfer) begin
                out_d = dec;
            end else if (dn_xfer) begin
                out_vld_d = 1'b0;
            end else if (up_xfer) begin
                // Downstream stalled while o_ready was already high.
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end else if (up_xfer) begin
            out_d     = dec;
            out_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end
`else
    assign o_ready = i_rst_n && (!out_vld_q || i_ready);

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (i_flush) begin
            out_vld_d = 1'b0;
        end else begin
            if (dn_xfer) out_vld_d = 1'b0;
            if (up_xfer) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (dn_xfer && out_q.ill && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_q      <= DEC_RST;
            out_vld_q  <= 1'b0;
            cnt_q      <= '0;
`ifdef ALU_DEC_SKID_EN
            skid_q     <= DEC_RST;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
`endif
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            cnt_q      <= cnt_d;
`ifdef ALU_DEC_SKID_EN
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
`endif
        end
    end

    assign o_valid       = out_vld_q;
    assign o_alu_ctrl    = out_q.op;
    assign o_src_b_imm   = out_q.imm;
    assign o_illegal     = out_q.ill;
    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_op_decoder
//
// Table of hand-decoded vectors, directed multi-cycle sequences (back-to-back,
// stall/drain, saturation, flush, mid-stream reset) and a randomized run
// scored against a queue-based reference model of the decode rules.
// ---------------------------------------------------------------------------

module tb_alu_op_decoder;
    import alu_op_decoder_pkg::*;

    localparam int CNT_W = 8;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic             o_valid;
    logic             i_ready;
    alu_op_t          o_alu_ctrl;
    logic             o_src_b_imm;
    logic             o_illegal;
    logic [CNT_W-1:0] o_illegal_cnt;

    alu_op_decoder #(.CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instr       (i_instr),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_alu_ctrl    (o_alu_ctrl),
        .o_src_b_imm   (o_src_b_imm),
        .o_illegal     (o_illegal),
        .o_illegal_cnt (o_illegal_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        alu_op_t op;
        logic    imm;
        logic    ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        alu_op_t     op;
        logic        imm;
        logic        ill;
    } vec_t;

    vec_t    tbl [19];
    alu_op_t base_map [8];
    alu_op_t br_map [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode: straight from the ISA tables.
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t       e;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        e.op  = OP_INVALID;
        e.imm = 1'b0;
        if (opc == 7'b0110011) begin
            if (f7 == 7'd0) e.op = base_map[f3];
            else if (f7 == 7'b0100000 && f3 == 3'd0) e.op = OP_SUB;
            else if (f7 == 7'b0100000 && f3 == 3'd5) e.op = OP_SRA;
        end else if (opc == 7'b0010011) begin
            e.imm = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'd0) e.op = base_map[f3];
                else if (f3 == 3'd5 && f7 == 7'b0100000) e.op = OP_SRA;
            end else begin
                e.op = base_map[f3];
            end
        end else if (opc inside {7'b0000011, 7'b0100011, 7'b0110111,
                                 7'b0010111, 7'b1101111, 7'b1100111}) begin
            e.op  = OP_ADD;
            e.imm = 1'b1;
        end else if (opc == 7'b1100011) begin
            e.op = br_map[f3 >> 1];
        end
        e.ill = (e.op == OP_INVALID);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  f7sel [3];
        logic [6:0]  misc [6];
        f7sel = '{7'd0, 7'b0100000, 7'(w[31:25] | 7'd1)};
        misc  = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        case ($urandom_range(0, 5))
            0: ;
            1: begin w[6:0] = 7'b0110011; w[31:25] = f7sel[$urandom_range(0, 2)]; end
            2: begin w[6:0] = 7'b0010011; w[31:25] = f7sel[$urandom_range(0, 2)]; end
            3: w[6:0] = 7'b1100011;
            4: w[6:0] = misc[$urandom_range(0, 5)];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Apply inputs just after the falling edge, then let combinational
    // outputs settle; the caller samples before the next rising edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
        @(negedge i_clk);
        i_valid = v;
        i_instr = ins;
        i_ready = r;
        i_flush = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_instr = 32'd0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int   exp_cnt;
        exp_t e0, e1;
        exp_t sq[$];
        logic [31:0] stall_w [8];
        int   idx;
        int   guard;

        base_map = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
        br_map   = '{OP_SUB, OP_INVALID, OP_SLT, OP_SLTU};

        tbl[0]  = '{32'h003100B3, OP_ADD,     1'b0, 1'b0};
        tbl[1]  = '{32'h403100B3, OP_SUB,     1'b0, 1'b0};
        tbl[2]  = '{32'h40315093, OP_SRA,     1'b1, 1'b0};
        tbl[3]  = '{32'h0020E063, OP_SLTU,    1'b0, 1'b0};
        tbl[4]  = '{32'h023100B3, OP_INVALID, 1'b0, 1'b1};
        tbl[5]  = '{32'h00000000, OP_INVALID, 1'b0, 1'b1};
        tbl[6]  = '{32'h00311093, OP_SLL,     1'b1, 1'b0};
        tbl[7]  = '{32'h02311093, OP_INVALID, 1'b1, 1'b1};
        tbl[8]  = '{32'h00314093, OP_XOR,     1'b1, 1'b0};
        tbl[9]  = '{32'h00002003, OP_ADD,     1'b1, 1'b0};
        tbl[10] = '{32'h000000EF, OP_ADD,     1'b1, 1'b0};
        tbl[11] = '{32'h00002063, OP_INVALID, 1'b0, 1'b1};
        tbl[12] = '{32'h00005063, OP_SLT,     1'b0, 1'b0};
        tbl[13] = '{32'h00001063, OP_SUB,     1'b0, 1'b0};
        tbl[14] = '{32'h00317093, OP_AND,     1'b1, 1'b0};
        tbl[15] = '{32'h00312033, OP_SLT,     1'b0, 1'b0};
        tbl[16] = '{32'h000000B7, OP_ADD,     1'b1, 1'b0};
        tbl[17] = '{32'h0000007F, OP_INVALID, 1'b0, 1'b1};
        tbl[18] = '{32'h40311033, OP_INVALID, 1'b0, 1'b1};

        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_instr = 32'd0;

        // ---- reset state ----
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ctrl", o_alu_ctrl, OP_INVALID);
        chk("rst_imm", o_src_b_imm, 0);
        chk("rst_ill", o_illegal, 0);
        chk("rst_cnt", o_illegal_cnt, 0);
        chk("rst_ready", o_ready, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("post_rst_ready", o_ready, 1);

        // ---- table: one instruction at a time, i_ready=1 ----
        exp_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, tbl[i].instr, 1'b1, 1'b0);
            chk("tbl_ready", o_ready, 1);
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            chk("tbl_valid", o_valid, 1);
            chk($sformatf("tbl%0d_ctrl", i), o_alu_ctrl, tbl[i].op);
            chk($sformatf("tbl%0d_imm", i), o_src_b_imm, tbl[i].imm);
            chk($sformatf("tbl%0d_ill", i), o_illegal, tbl[i].ill);
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            chk("tbl_drained", o_valid, 0);
            if (tbl[i].ill) exp_cnt++;
            chk($sformatf("tbl%0d_cnt", i), o_illegal_cnt, exp_cnt);
        end

        // ---- back-to-back SUB then SRAI ----
        drive(1'b1, 32'h403100B3, 1'b1, 1'b0);
        drive(1'b1, 32'h40315093, 1'b1, 1'b0);
        chk("b2b_v0", o_valid, 1);
        chk("b2b_op0", o_alu_ctrl, OP_SUB);
        chk("b2b_imm0", o_src_b_imm, 0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("b2b_v1", o_valid, 1);
        chk("b2b_op1", o_alu_ctrl, OP_SRA);
        chk("b2b_imm1", o_src_b_imm, 1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("b2b_end", o_valid, 0);

        // ---- stall 5 cycles with i_valid=1, then drain ----
        stall_w = '{32'h003100B3, 32'h403100B3, 32'h00314093, 32'h00317093,
                    32'h00311093, 32'h0020E063, 32'h00005063, 32'h00312033};
        idx = 0;
        sq.delete();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, stall_w[idx], 1'b0, 1'b0);
            if (c > 0) begin
                e0 = ref_dec(stall_w[0]);
                chk("stall_valid", o_valid, 1);
                chk("stall_ctrl", o_alu_ctrl, e0.op);
                chk("stall_imm", o_src_b_imm, e0.imm);
            end
            if (o_ready) begin
                sq.push_back(ref_dec(stall_w[idx]));
                idx++;
            end
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("stall_ready_low", o_ready, 0);
`ifdef ALU_DEC_SKID_EN
        chk("stall_accepted", sq.size(), 2);
`else
        chk("stall_accepted", sq.size(), 1);
`endif
        guard = 0;
        while (sq.size() > 0 && guard < 10) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            guard++;
            if (o_valid) begin
                e1 = sq.pop_front();
                chk("drain_ctrl", o_alu_ctrl, e1.op);
                chk("drain_imm", o_src_b_imm, e1.imm);
            end
        end
        chk("drain_timeout", sq.size(), 0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain_no_dup", o_valid, 0);

        // ---- saturation: 300 illegal words ----
        do_reset();
        for (int i = 0; i < 300; i++) drive(1'b1, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("sat_cnt", o_illegal_cnt, 255);

        // ---- flush with held entry, i_ready=0 ----
        do_reset();
        drive(1'b1, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("fl_held", o_valid, 1);
        drive(1'b1, 32'h003100B3, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("fl_valid", o_valid, 0);
        chk("fl_cnt", o_illegal_cnt, 0);
        // flush wins over a simultaneous downstream transfer
        drive(1'b1, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("fl2_valid", o_valid, 0);
        chk("fl2_cnt", o_illegal_cnt, 0);

        // ---- reset mid-stream ----
        drive(1'b1, 32'h003100B3, 1'b0, 1'b0);
        drive(1'b1, 32'h40315093, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_ready", o_ready, 0);
        @(negedge i_clk);
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_ctrl", o_alu_ctrl, OP_INVALID);
        chk("mrst_imm", o_src_b_imm, 0);
        chk("mrst_ill", o_illegal, 0);
        chk("mrst_cnt", o_illegal_cnt, 0);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("mrst_ready_up", o_ready, 1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("mrst_no_out", o_valid, 0);

        // ---- randomized run vs reference model ----
        do_reset();
        sq.delete();
        exp_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 3) != 0), gen_instr(),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            chk("rnd_valid", o_valid, (sq.size() > 0));
            chk("rnd_cnt", o_illegal_cnt, exp_cnt);
`ifdef ALU_DEC_SKID_EN
            chk("rnd_ready", o_ready, (sq.size() < 2));
`else
            chk("rnd_ready", o_ready, (sq.size() == 0 || i_ready));
`endif
            if (sq.size() > 0) begin
                chk("rnd_ctrl", o_alu_ctrl, sq[0].op);
                chk("rnd_imm", o_src_b_imm, sq[0].imm);
                chk("rnd_ill", o_illegal, sq[0].ill);
            end
            if (i_flush) begin
                sq.delete();
            end else begin
                if (o_valid && i_ready && sq.size() > 0) begin
                    e1 = sq.pop_front();
                    if (e1.ill && exp_cnt < 255) exp_cnt++;
                end
                if (i_valid && o_ready) sq.push_back(ref_dec(i_instr));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
